hex_ascii_streamer: RTL
=======================

# hex_ascii_streamer

Parametrised hex-to-text serializer for the serial hex calculator output path. It accepts a DIGITS-nibble binary word over a valid/ready handshake and emits it as a stream of ASCII bytes, one byte per output handshake, toward the UART transmitter. Options cover an optional "0x" prefix, an optional CR/LF terminator, upper or lower case A–F, and leading-zero suppression.

## Interface
- DIGITS, 4: number of hex nibbles per input word (1..16).
- PREFIX_EN, 1: 1 = emit "0x" (8'h30, 8'h78) before the digits.
- TERM_EN, 1: 1 = emit CR, LF (8'h0D, 8'h0A) after the digits.
- CLK  in  1  clock; all logic on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- IN_VALID  in  1  input word valid.
- IN_READY  out  1  block can accept a word.
- IN_DATA  in  4*DIGITS  word; nibble DIGITS-1 is the most significant.
- LOWER  in  1  1 = a–f (8'h61..66), 0 = A–F (8'h41..46); sampled at accept.
- SUPPRESS_LZ  in  1  1 = drop leading zero nibbles; sampled at accept.
- OUT_VALID  out  1  OUT_DATA holds a character.
- OUT_READY  in  1  sink accepts the character.
- OUT_DATA  out  8  ASCII character.
- OUT_LAST  out  1  current character is the last of the word.
- BUSY  out  1  a word is in flight (state != IDLE).

## Operation
- FSM states: IDLE, PFX0, PFX1, DIG, CR, LF.
- IDLE: IN_READY=1. Accept = IN_VALID && IN_READY. On accept, latch IN_DATA, LOWER, SUPPRESS_LZ. Load the digit index with DIGITS-1, or, if SUPPRESS_LZ, with the index of the highest non-zero nibble (0 if the word is all zero). Go to PFX0 if PREFIX_EN, else DIG.
- Each non-IDLE state presents one character with OUT_VALID=1. It advances only on OUT_VALID && OUT_READY.
- PFX0 '0' → PFX1 'x' → DIG.
- DIG: presents the ASCII of the nibble at the index. Nibbles 0–9 map to 8'h30+n. Nibbles A–F map to 8'h41+(n-10), or 8'h61+(n-10) when LOWER. On handshake: if index>0, decrement it and stay in DIG; else go to CR if TERM_EN, else IDLE.
- CR → LF → IDLE.
- The least-significant digit is always emitted, so an all-zero word produces "0".
- OUT_LAST=1 only on the final character: LF if TERM_EN, else digit index 0.
- Characters per word = 2·PREFIX_EN + emitted digits + 2·TERM_EN.
- IN_VALID is ignored while not in IDLE. There is no queueing.

## Timing
- Reset (RST_N low at an edge): state IDLE, OUT_VALID=0, OUT_DATA=8'h00, OUT_LAST=0, BUSY=0, latched word and index cleared.
- IN_READY is forced to 0 while RST_N is low. It is 1 from the first cycle after reset release.
- Reset mid-word aborts the word. No further characters are emitted, and the next accepted word starts from its first character.
- Accept at edge T: first character valid from T+1.
- OUT_DATA and OUT_LAST are registered and change only on a completed output handshake or on accept.
- With OUT_READY held high, the block emits one character per cycle with no bubbles inside a word.
- Last-character handshake at edge T: state returns to IDLE and IN_READY=1 in cycle T+1. The next word can be accepted at edge T+1, and its first character appears at T+2. That gives one idle output cycle between words.
- While OUT_READY=0, OUT_DATA, OUT_LAST and OUT_VALID hold stable, with no timeout.

## Structure
- Shared package (hex_ascii_pkg):
  - state enum.
  - Character constants: ASCII_ZERO 8'h30, ASCII_X 8'h78, ASCII_UA 8'h41, ASCII_LA 8'h61, ASCII_CR 8'h0D, ASCII_LF 8'h0A.
- Sub-module nibble_to_ascii: combinational, 4-bit nibble plus LOWER in, 8-bit ASCII out. Instantiated once on the selected nibble.
- Leading-nibble search is a combinational priority encoder, clog2(DIGITS) wide, inside the top level.

## Test plan
- DIGITS=4, defaults, IN_DATA=16'h1A3F, LOWER=0, SUPPRESS_LZ=0, OUT_READY=1 → 30 78 31 41 33 46 0D 0A on 8 consecutive cycles starting T+1. OUT_LAST only on 0A; IN_READY=1 the cycle after.
- IN_DATA=16'h00BE, LOWER=1, SUPPRESS_LZ=1 → 30 78 62 65 0D 0A.
- IN_DATA=16'h0000, SUPPRESS_LZ=1 → 30 78 30 0D 0A. With SUPPRESS_LZ=0 → 30 78 30 30 30 30 0D 0A.
- Backpressure: drop OUT_READY for 3 cycles while 8'h41 is presented, and pulse IN_VALID with 16'hFFFF.
  - OUT_DATA must stay 41 and OUT_VALID stay 1 for all 3 cycles.
  - IN_READY must stay 0 and the pulsed word must not be accepted.
  - The stream resumes with 33.
- Assert RST_N=0 for one cycle after the third character of 16'h1A3F → next cycle OUT_VALID=0, BUSY=0. The next word 16'h0007 (SUPPRESS_LZ=1) yields 30 78 37 0D 0A.
- DIGITS=2, PREFIX_EN=0, TERM_EN=0, IN_DATA=8'hF0 → 46 30, OUT_LAST on 30. A back-to-back second word starts exactly 2 cycles after the last handshake.

Source files
------------

// File: rtl/hex_ascii_pkg.sv
// Shared types and character constants for the hex-to-ASCII output path.
// Imported by the streamer top level and its nibble converter.
package hex_ascii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PFX0 = 3'd1,
    ST_PFX1 = 3'd2,
    ST_DIG  = 3'd3,
    ST_CR   = 3'd4,
    ST_LF   = 3'd5
  } state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_X    = 8'h78;
  localparam logic [7:0] ASCII_UA   = 8'h41;
  localparam logic [7:0] ASCII_LA   = 8'h61;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // One hex nibble to its ASCII glyph; letters follow the requested case.
  function automatic logic [7:0] hex_char(input logic [3:0] nib, input logic lower);
    logic [7:0] ch;
    if (nib < 4'd10) begin
      ch = ASCII_ZERO + {4'h0, nib};
    end else if (lower) begin
      ch = ASCII_LA + {4'h0, nib} - 8'd10;
    end else begin
      ch = ASCII_UA + {4'h0, nib} - 8'd10;
    end
    return ch;
  endfunction

endpackage

// File: rtl/hex_ascii_streamer_if.sv
// Word-in / character-out handshake bundle for hex_ascii_streamer.
// The slave modport is the streamer's view; master is the driver/sink view.
interface hex_ascii_streamer_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_data;
  logic                  lower;
  logic                  suppress_lz;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_data;
  logic                  out_last;
  logic                  busy;

  modport master (
    output in_valid, in_data, lower, suppress_lz, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, lower, suppress_lz, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/nibble_to_ascii.sv
// Combinational converter from one hex nibble to its ASCII character.
module nibble_to_ascii
  import hex_ascii_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       lower,
  output logic [7:0] ascii
);

  // Pure lookup, no state
  always_comb begin
    ascii = hex_char(nib, lower);
  end

endmodule

// File: rtl/hex_ascii_streamer.sv
// Serializes a DIGITS-nibble word into ASCII hex text, one character per
// output handshake, with optional "0x" prefix and CR/LF terminator.
module hex_ascii_streamer
  import hex_ascii_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter bit PREFIX_EN = 1'b1,
  parameter bit TERM_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hex_ascii_streamer_if.slave  bus
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] IDX_MSB = IDXW'(DIGITS - 1);

  state_e            state_r;
  state_e            state_s;
  logic [W-1:0]      data_r;
  logic [W-1:0]      data_s;
  logic              lower_r;
  logic              lower_s;
  logic [IDXW-1:0]   idx_r;
  logic [IDXW-1:0]   idx_s;
  logic [IDXW-1:0]   lz_idx_s;
  logic [3:0]        nib_s;
  logic [7:0]        nib_ascii_s;
  logic [7:0]        char_s;
  logic              last_s;
  logic              upd_s;
  logic              accept_s;
  logic              hs_s;
  logic              out_valid_r;
  logic [7:0]        out_data_r;
  logic              out_last_r;

  assign bus.in_ready  = (state_r == ST_IDLE) && rst_n;
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;

  assign accept_s = bus.in_valid && bus.in_ready;
  assign hs_s     = out_valid_r && bus.out_ready;

  // Highest non-zero nibble of the incoming word; 0 for an all-zero word
  always_comb begin
    lz_idx_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.in_data[4*i +: 4] != 4'h0) begin
        lz_idx_s = IDXW'(i);
      end else begin
        lz_idx_s = lz_idx_s;
      end
    end
  end

  // Next-state, word latch and digit index sequencing
  always_comb begin
    state_s = state_r;
    data_s  = data_r;
    lower_s = lower_r;
    idx_s   = idx_r;
    upd_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          data_s  = bus.in_data;
          lower_s = bus.lower;
          idx_s   = bus.suppress_lz ? lz_idx_s : IDX_MSB;
          state_s = PREFIX_EN ? ST_PFX0 : ST_DIG;
          upd_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PFX0: begin
        if (hs_s) begin
          state_s = ST_PFX1;
          upd_s   = 1'b1;
        end else begin
          state_s = ST_PFX0;
        end
      end
      ST_PFX1: begin
        if (hs_s) begin
          state_s = ST_DIG;
          upd_s   = 1'b1;
        end else begin
          state_s = ST_PFX1;
        end
      end
      ST_DIG: begin
        if (hs_s) begin
          upd_s = 1'b1;
          if (idx_r != '0) begin
            idx_s = idx_r - IDXW'(1);
          end else begin
            state_s = TERM_EN ? ST_CR : ST_IDLE;
          end
        end else begin
          state_s = ST_DIG;
        end
      end
      ST_CR: begin
        if (hs_s) begin
          state_s = ST_LF;
          upd_s   = 1'b1;
        end else begin
          state_s = ST_CR;
        end
      end
      ST_LF: begin
        if (hs_s) begin
          state_s = ST_IDLE;
          upd_s   = 1'b1;
        end else begin
          state_s = ST_LF;
        end
      end
      default: begin
        state_s = ST_IDLE;
        upd_s   = 1'b1;
      end
    endcase
  end

  // Nibble that the next DIG character will show
  always_comb begin
    nib_s = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_s == IDXW'(i)) begin
        nib_s = data_s[4*i +: 4];
      end else begin
        nib_s = nib_s;
      end
    end
  end

  nibble_to_ascii u_nib (
    .nib   (nib_s),
    .lower (lower_s),
    .ascii (nib_ascii_s)
  );

  // Character and last flag for the state being entered
  always_comb begin
    char_s = 8'h00;
    last_s = 1'b0;
    case (state_s)
      ST_PFX0: char_s = ASCII_ZERO;
      ST_PFX1: char_s = ASCII_X;
      ST_DIG: begin
        char_s = nib_ascii_s;
        last_s = (idx_s == '0) && (TERM_EN == 1'b0);
      end
      ST_CR:   char_s = ASCII_CR;
      ST_LF: begin
        char_s = ASCII_LF;
        last_s = 1'b1;
      end
      default: begin
        char_s = 8'h00;
        last_s = 1'b0;
      end
    endcase
  end

  // State and output registers; outputs move only on accept or handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      data_r      <= '0;
      lower_r     <= 1'b0;
      idx_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      out_last_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      data_r  <= data_s;
      lower_r <= lower_s;
      idx_r   <= idx_s;
      if (upd_s) begin
        out_valid_r <= (state_s != ST_IDLE);
        out_data_r  <= char_s;
        out_last_r  <= last_s;
      end else begin
        out_valid_r <= out_valid_r;
        out_data_r  <= out_data_r;
        out_last_r  <= out_last_r;
      end
    end
  end

endmodule
